// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multi-cycle RV32I control FSM and its datapath.
// The FSM side (master) consumes opcode/flags and drives every select and enable.
interface multicycle_control_fsm_if;
  localparam int unsigned OP_W  = 7;
  localparam int unsigned SEL_W = 2;

  // Inputs to the FSM from the instruction register, ALU and memory
  logic [OP_W-1:0]  op;
  logic             Zero;
  logic             mem_ready;

  // Datapath controls
  logic             PCWrite;
  logic             AdrSrc;
  logic             MemWrite;
  logic             IRWrite;
  logic [SEL_W-1:0] ResultSrc;
  logic [SEL_W-1:0] ALUSrcA;
  logic [SEL_W-1:0] ALUSrcB;
  logic [SEL_W-1:0] ALUOp;
  logic [SEL_W-1:0] ImmSrc;
  logic             RegWrite;
  logic             illegal;

  modport master (
    input  op, Zero, mem_ready,
    output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ALUOp, ImmSrc, RegWrite, illegal
  );

  modport slave (
    output op, Zero, mem_ready,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ALUOp, ImmSrc, RegWrite, illegal
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Main control FSM of the multi-cycle RV32I core: sequences the shared ALU,
// unified memory port and register file; Moore selects plus handshake-gated enables.
module multicycle_control_fsm (
  input  logic                      clk,
  input  logic                      rst,
  multicycle_control_fsm_if.master  bus,
  output logic [3:0]                state
);

  localparam int unsigned STATE_W = 4;
  localparam int unsigned OP_W    = 7;
  localparam int unsigned SEL_W   = 2;

  localparam logic [OP_W-1:0] OP_LW   = 7'b0000011;
  localparam logic [OP_W-1:0] OP_SW   = 7'b0100011;
  localparam logic [OP_W-1:0] OP_R    = 7'b0110011;
  localparam logic [OP_W-1:0] OP_IALU = 7'b0010011;
  localparam logic [OP_W-1:0] OP_BEQ  = 7'b1100011;
  localparam logic [OP_W-1:0] OP_JAL  = 7'b1101111;

  localparam logic [SEL_W-1:0] RES_ALUOUT    = 2'b00;
  localparam logic [SEL_W-1:0] RES_DATA      = 2'b01;
  localparam logic [SEL_W-1:0] RES_ALURESULT = 2'b10;

  localparam logic [SEL_W-1:0] SRCA_PC    = 2'b00;
  localparam logic [SEL_W-1:0] SRCA_OLDPC = 2'b01;
  localparam logic [SEL_W-1:0] SRCA_RS1   = 2'b10;

  localparam logic [SEL_W-1:0] SRCB_RS2  = 2'b00;
  localparam logic [SEL_W-1:0] SRCB_IMM  = 2'b01;
  localparam logic [SEL_W-1:0] SRCB_FOUR = 2'b10;

  localparam logic [SEL_W-1:0] ALUOP_ADD   = 2'b00;
  localparam logic [SEL_W-1:0] ALUOP_SUB   = 2'b01;
  localparam logic [SEL_W-1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [SEL_W-1:0] IMM_I = 2'b00;
  localparam logic [SEL_W-1:0] IMM_S = 2'b01;
  localparam logic [SEL_W-1:0] IMM_B = 2'b10;
  localparam logic [SEL_W-1:0] IMM_J = 2'b11;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  state_t state_q;
  state_t state_d;

  logic is_lw;
  logic is_sw;
  logic is_r;
  logic is_ialu;
  logic is_beq;
  logic is_jal;

  // Raw (pre-reset-gating) enables produced by the output decoder
  logic pc_update;
  logic branch;
  logic ir_write_raw;
  logic mem_write_raw;
  logic reg_write_raw;
  logic illegal_raw;

  assign is_lw   = (bus.op == OP_LW);
  assign is_sw   = (bus.op == OP_SW);
  assign is_r    = (bus.op == OP_R);
  assign is_ialu = (bus.op == OP_IALU);
  assign is_beq  = (bus.op == OP_BEQ);
  assign is_jal  = (bus.op == OP_JAL);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; unused codes fall back to FETCH
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:    state_d = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (is_lw || is_sw) begin
          state_d = S_MEMADR;
        end else if (is_r) begin
          state_d = S_EXECUTER;
        end else if (is_ialu) begin
          state_d = S_EXECUTEI;
        end else if (is_beq) begin
          state_d = S_BEQ;
        end else if (is_jal) begin
          state_d = S_JAL;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_MEMADR: begin
        if (is_lw) begin
          state_d = S_MEMREAD;
        end else if (is_sw) begin
          state_d = S_MEMWRITE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_MEMREAD:  state_d = bus.mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE: state_d = bus.mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_JAL:      state_d = S_ALUWB;
      S_MEMWB:    state_d = S_FETCH;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  // Moore selects per state; enables are gated off for the whole reset cycle
  always_comb begin
    bus.AdrSrc    = 1'b0;
    bus.ResultSrc = RES_ALUOUT;
    bus.ALUSrcA   = SRCA_PC;
    bus.ALUSrcB   = SRCB_RS2;
    bus.ALUOp     = ALUOP_ADD;
    pc_update     = 1'b0;
    branch        = 1'b0;
    ir_write_raw  = 1'b0;
    mem_write_raw = 1'b0;
    reg_write_raw = 1'b0;
    illegal_raw   = 1'b0;
    case (state_q)
      S_FETCH: begin
        bus.AdrSrc    = 1'b0;
        bus.ALUSrcA   = SRCA_PC;
        bus.ALUSrcB   = SRCB_FOUR;
        bus.ALUOp     = ALUOP_ADD;
        bus.ResultSrc = RES_ALURESULT;
        ir_write_raw  = bus.mem_ready;
        pc_update     = bus.mem_ready;
      end
      S_DECODE: begin
        bus.ALUSrcA = SRCA_OLDPC;
        bus.ALUSrcB = SRCB_IMM;
        bus.ALUOp   = ALUOP_ADD;
        illegal_raw = !(is_lw || is_sw || is_r || is_ialu || is_beq || is_jal);
      end
      S_MEMADR: begin
        bus.ALUSrcA = SRCA_RS1;
        bus.ALUSrcB = SRCB_IMM;
        bus.ALUOp   = ALUOP_ADD;
      end
      S_MEMREAD: begin
        bus.AdrSrc = 1'b1;
      end
      S_MEMWRITE: begin
        bus.AdrSrc    = 1'b1;
        mem_write_raw = bus.mem_ready;
      end
      S_MEMWB: begin
        bus.ResultSrc = RES_DATA;
        reg_write_raw = 1'b1;
      end
      S_EXECUTER: begin
        bus.ALUSrcA = SRCA_RS1;
        bus.ALUSrcB = SRCB_RS2;
        bus.ALUOp   = ALUOP_FUNCT;
      end
      S_EXECUTEI: begin
        bus.ALUSrcA = SRCA_RS1;
        bus.ALUSrcB = SRCB_IMM;
        bus.ALUOp   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        bus.ResultSrc = RES_ALUOUT;
        reg_write_raw = 1'b1;
      end
      S_BEQ: begin
        bus.ALUSrcA   = SRCA_RS1;
        bus.ALUSrcB   = SRCB_RS2;
        bus.ALUOp     = ALUOP_SUB;
        bus.ResultSrc = RES_ALUOUT;
        branch        = 1'b1;
      end
      S_JAL: begin
        bus.ALUSrcA   = SRCA_OLDPC;
        bus.ALUSrcB   = SRCB_FOUR;
        bus.ALUOp     = ALUOP_ADD;
        bus.ResultSrc = RES_ALUOUT;
        pc_update     = 1'b1;
      end
      default: begin
        bus.AdrSrc = 1'b0;
      end
    endcase

    // Branch resolves on Zero within the BEQ cycle itself
    bus.PCWrite  = ((branch & bus.Zero) | pc_update) & ~rst;
    bus.IRWrite  = ir_write_raw  & ~rst;
    bus.MemWrite = mem_write_raw & ~rst;
    bus.RegWrite = reg_write_raw & ~rst;
    bus.illegal  = illegal_raw   & ~rst;
  end

  // Immediate format follows the opcode directly, independent of state
  always_comb begin
    bus.ImmSrc = IMM_I;
    case (bus.op)
      OP_LW:   bus.ImmSrc = IMM_I;
      OP_IALU: bus.ImmSrc = IMM_I;
      OP_SW:   bus.ImmSrc = IMM_S;
      OP_BEQ:  bus.ImmSrc = IMM_B;
      OP_JAL:  bus.ImmSrc = IMM_J;
      default: bus.ImmSrc = IMM_I;
    endcase
  end

  assign state = STATE_W'(state_q);

endmodule
